// File: rtl/alu_word_sequencer_pkg.sv
// rtl/alu_word_sequencer_pkg.sv - shared op codes, flag indices and FSM states for the word sequencer
package alu_word_sequencer_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0110;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: legal = 1'b1;
            default:                               legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_word_sequencer_alu.sv
// rtl/alu_word_sequencer_alu.sv - combinational single-word ALU producing {V,N,C,Z}
module alu_word_sequencer_alu
    import alu_word_sequencer_pkg::*;
#(
    parameter int DataWidth = 8
) (
    input  logic [DataWidth-1:0] a,
    input  logic [DataWidth-1:0] b,
    input  logic                 cin,
    input  logic [3:0]           op,
    output logic [DataWidth-1:0] y,
    output logic [3:0]           flags
);

    logic [DataWidth:0] sum;
    logic               c;
    logic               v;

    // One word of add-with-carry or bitwise logic; subtraction arrives here as add of ~b.
    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {{DataWidth{1'b0}}, cin};
        y   = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            OP_ADD: begin
                y = sum[DataWidth-1:0];
                c = sum[DataWidth];
                v = (a[DataWidth-1] == b[DataWidth-1]) && (y[DataWidth-1] != a[DataWidth-1]);
            end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = '0;
        endcase
        flags         = '0;
        flags[FLAG_Z] = (y == '0);
        flags[FLAG_C] = c;
        flags[FLAG_N] = y[DataWidth-1];
        flags[FLAG_V] = v;
    end

endmodule

// File: rtl/alu_word_sequencer.sv
// rtl/alu_word_sequencer.sv - multi-word ALU sequencer with carry chaining; ALU_SEQ_CARRYIN_EN adds CIn
module alu_word_sequencer
    import alu_word_sequencer_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int Words     = 4,
    parameter int FlagBits  = 4
) (
    input  logic                       Clk,
    input  logic                       Reset_N,
    input  logic                       Start,
    input  logic [3:0]                 Op,
    input  logic [DataWidth*Words-1:0] A,
    input  logic [DataWidth*Words-1:0] B,
`ifdef ALU_SEQ_CARRYIN_EN
    input  logic                       CIn,
`endif
    output logic                       Busy,
    output logic                       Done,
    output logic                       Err,
    output logic [DataWidth*Words-1:0] Y,
    output logic [FlagBits-1:0]        OFlags
);

    localparam int W  = DataWidth * Words;
    localparam int IW = $clog2(Words);
    localparam logic [IW-1:0] LAST_IDX = IW'(Words - 1);

    state_t               state;
    logic [W-1:0]         a_q;
    logic [W-1:0]         b_q;
    logic [3:0]           op_q;
    logic [IW-1:0]        idx;
    logic                 carry_q;
    logic                 zacc;
    logic                 cin0_q;

    logic                 is_sub;
    logic                 is_arith;
    logic [DataWidth-1:0] alu_a;
    logic [DataWidth-1:0] alu_b;
    logic                 alu_cin;
    logic [3:0]           alu_op;
    logic [DataWidth-1:0] alu_y;
    logic [3:0]           alu_flags;
    logic [FlagBits-1:0]  flags_final;

    // Word mux and operand conditioning: Sub becomes A + ~B with the chained carry.
    always_comb begin
        is_sub   = (op_q == OP_SUB);
        is_arith = (op_q == OP_ADD) || is_sub;
        alu_a    = a_q[idx*DataWidth +: DataWidth];
        alu_b    = is_sub ? ~b_q[idx*DataWidth +: DataWidth] : b_q[idx*DataWidth +: DataWidth];
        alu_op   = is_arith ? OP_ADD : op_q;
        alu_cin  = (idx == '0) ? cin0_q : carry_q;

        flags_final         = '0;
        flags_final[FLAG_V] = alu_flags[FLAG_V];
        flags_final[FLAG_N] = alu_flags[FLAG_N];
        flags_final[FLAG_C] = is_arith & alu_flags[FLAG_C];
        flags_final[FLAG_Z] = zacc & alu_flags[FLAG_Z];
    end

    alu_word_sequencer_alu #(
        .DataWidth (DataWidth)
    ) u_alu (
        .a     (alu_a),
        .b     (alu_b),
        .cin   (alu_cin),
        .op    (alu_op),
        .y     (alu_y),
        .flags (alu_flags)
    );

    // Request FSM: latch on Start, walk the words low to high, pulse Done once.
    always_ff @(posedge Clk or negedge Reset_N) begin
        if (!Reset_N) begin
            state   <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            idx     <= '0;
            carry_q <= 1'b0;
            zacc    <= 1'b1;
            cin0_q  <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
            Err     <= 1'b0;
            Y       <= '0;
            OFlags  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= Op;
                        idx   <= '0;
                        zacc  <= 1'b1;
`ifdef ALU_SEQ_CARRYIN_EN
                        cin0_q <= CIn;
`else
                        cin0_q <= (Op == OP_SUB);
`endif
                        Busy  <= 1'b1;
                        if (op_is_legal(Op)) begin
                            state <= ST_RUN;
                        end else begin
                            state <= ST_DONE;
                            Done  <= 1'b1;
                            Err   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    Y[idx*DataWidth +: DataWidth] <= alu_y;
                    zacc    <= zacc & alu_flags[FLAG_Z];
                    carry_q <= alu_flags[FLAG_C];
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        OFlags <= flags_final;
                        state  <= ST_DONE;
                        Done   <= 1'b1;
                        Err    <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    Err   <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_word_sequencer.sv
// tb/tb_alu_word_sequencer.sv - self-checking bench for alu_word_sequencer (Words=4, DataWidth=8)
module tb_alu_word_sequencer;

    localparam int DW    = 8;
    localparam int WORDS = 4;
    localparam int W     = DW * WORDS;

    logic         Clk     = 1'b0;
    logic         Reset_N = 1'b0;
    logic         Start   = 1'b0;
    logic [3:0]   Op      = 4'h0;
    logic [W-1:0] A       = '0;
    logic [W-1:0] B       = '0;
    logic         cin_drv = 1'b0;
    logic         Busy;
    logic         Done;
    logic         Err;
    logic [W-1:0] Y;
    logic [3:0]   OFlags;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    alu_word_sequencer #(
        .DataWidth (DW),
        .Words     (WORDS),
        .FlagBits  (4)
    ) dut (
        .Clk     (Clk),
        .Reset_N (Reset_N),
        .Start   (Start),
        .Op      (Op),
        .A       (A),
        .B       (B),
`ifdef ALU_SEQ_CARRYIN_EN
        .CIn     (cin_drv),
`endif
        .Busy    (Busy),
        .Done    (Done),
        .Err     (Err),
        .Y       (Y),
        .OFlags  (OFlags)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic bit legal(input logic [3:0] op);
        return op == 4'h0 || op == 4'h1 || op == 4'h3 || op == 4'h4 || op == 4'h6;
    endfunction

    // Whole-operand reference: returns {V,N,C,Z, Y}
    function automatic logic [W+3:0] model_op(input logic [3:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b, input logic cin);
        logic [W:0]   wide;
        logic [W-1:0] y;
        logic         c;
        logic         v;
        logic         borrow;
        c = 1'b0;
        v = 1'b0;
        y = '0;
        case (op)
            4'h0: begin
                wide = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                y    = wide[W-1:0];
                c    = wide[W];
                v    = (a[W-1] == b[W-1]) && (y[W-1] != a[W-1]);
            end
            4'h1: begin
                borrow = !cin;
                y      = a - b - W'(borrow);
                c      = ({1'b0, a} >= ({1'b0, b} + (W+1)'(borrow)));
                v      = (a[W-1] != b[W-1]) && (y[W-1] != a[W-1]);
            end
            4'h3: y = a & b;
            4'h4: y = a | b;
            4'h6: y = a ^ b;
            default: y = '0;
        endcase
        return {v, y[W-1], c, (y == '0), y};
    endfunction

    int           busy_left = 0;
    bit           m_err     = 1'b0;
    logic [W-1:0] m_y       = '0;
    logic [W-1:0] n_y       = '0;
    logic [3:0]   m_f       = 4'h0;
    logic [3:0]   n_f       = 4'h0;
    logic         cin_eff;

    // Timeline model plus per-cycle comparison of every DUT output
    always @(posedge Clk) begin
        if (!Reset_N) begin
            busy_left = 0;
            m_err     = 1'b0;
            m_y       = '0;
            m_f       = 4'h0;
        end else if (busy_left == 0) begin
            if (Start) begin
                if (legal(Op)) begin
`ifdef ALU_SEQ_CARRYIN_EN
                    cin_eff = cin_drv;
`else
                    cin_eff = (Op == 4'h1);
`endif
                    {n_f, n_y} = model_op(Op, A, B, cin_eff);
                    m_err      = 1'b0;
                    busy_left  = WORDS + 1;
                end else begin
                    m_err     = 1'b1;
                    busy_left = 1;
                end
            end
        end else begin
            busy_left--;
            if (busy_left == 1 && !m_err) begin
                m_y = n_y;
                m_f = n_f;
            end
        end
        #1;
        chk("busy", Busy, busy_left > 0);
        chk("done", Done, busy_left == 1);
        chk("err", Err, busy_left == 1 && m_err);
        chk("oflags", OFlags, m_f);
        if (busy_left <= 1) chk("y", Y, m_y);
    end

    task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, input bit poke, input logic exp_err,
                         input logic [W-1:0] exp_y, input logic [3:0] exp_f, input int exp_lat);
        bit seen;
        int lat;
        @(negedge Clk);
        Op      = op;
        A       = a;
        B       = b;
        cin_drv = cin;
        Start   = 1'b1;
        seen    = 1'b0;
        lat     = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(posedge Clk);
            #1;
            if (i == 1) Start = 1'b0;
            if (poke && i == 2) begin
                Start = 1'b1;
                Op    = 4'h4;
                A     = 32'hDEAD_BEEF;
            end
            if (poke && i == 3) Start = 1'b0;
            if (Done) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        chk("done_seen", seen, 1'b1);
        chk("latency", lat, exp_lat);
        chk("lit_err", Err, exp_err);
        chk("lit_y", Y, exp_y);
        chk("lit_flags", OFlags, exp_f);
        @(negedge Clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge Clk);
        Reset_N = 1'b1;

        do_op(4'h0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 4'b0000, 5);
        do_op(4'h0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'b0011, 5);
        do_op(4'h0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 4'b1100, 5);
        do_op(4'h1, 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'b0100, 5);
        do_op(4'h1, 32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0011, 5);
        do_op(4'h1, 32'h0001_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'h0000_FFFF, 4'b0010, 5);
        do_op(4'h1, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 4'b1010, 5);
        do_op(4'h6, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0, 1'b0, 1'b0, 32'h0F0F_F0F0, 4'b0000, 5);
        do_op(4'hF, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 32'h0F0F_F0F0, 4'b0000, 1);
        do_op(4'h3, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b0, 32'h0204_0608, 4'b0000, 5);
        do_op(4'h4, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 4'b0100, 5);
        do_op(4'h2, 32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 1'b1, 32'h8000_0001, 4'b0100, 1);

        // Abort a request while word 2 is being processed
        @(negedge Clk);
        Op      = 4'h0;
        A       = 32'h1111_1111;
        B       = 32'h2222_2222;
        cin_drv = 1'b0;
        Start   = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        @(negedge Clk);
        Reset_N = 1'b0;
        #1;
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_err", Err, 1'b0);
        chk("rst_y", Y, 32'h0);
        chk("rst_flags", OFlags, 4'h0);
        @(negedge Clk);
        Reset_N = 1'b1;

        do_op(4'h0, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 32'h0000_0008, 4'b0000, 5);
`ifdef ALU_SEQ_CARRYIN_EN
        do_op(4'h0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'b0011, 5);
`endif
        repeat (2) @(negedge Clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
